// File: rtl/nap_countdown_pkg.sv
// Shared types and constants for the nap countdown timer.
// Holds the state encoding, BCD limits and a BCD digit check.
package nap_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      ALARM = 2'd2,
      RSVD  = 2'd3
   } state_t;

   localparam logic [7:0] BCD_ZERO       = 8'h00;
   localparam logic [7:0] HOUR_MAX_DEF   = 8'h23;
   localparam logic [7:0] MINSEC_MAX_DEF = 8'h59;

   function automatic logic bcd_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd2_dec.sv
// Two-digit BCD decrementer; at 00 it reloads the wrap value and raises borrow.
// Purely combinational so three of them chain within a single cycle.
module bcd2_dec
   import nap_pkg::*;
(
   input  logic [7:0] value,
   input  logic       dec_en,
   input  logic [7:0] wrap,
   output logic [7:0] next_value,
   output logic       borrow
);

   always_comb begin
      next_value = value;
      borrow     = 1'b0;
      if (dec_en) begin
         if (value == BCD_ZERO) begin
            next_value = wrap;
            borrow     = 1'b1;
         end else if (value[3:0] == 4'd0) begin
            next_value = {value[7:4] - 4'd1, 4'd9};
         end else begin
            next_value = {value[7:4], value[3:0] - 4'd1};
         end
      end
   end

endmodule

// File: rtl/nap_countdown.sv
// Nap timer: keypad entry of hh:mm:ss in BCD, validation on completeSetting,
// once-per-second countdown and a latched alarm at zero.
module nap_countdown
   import nap_pkg::*;
#(
   parameter logic [7:0] HOUR_MAX   = HOUR_MAX_DEF,
   parameter logic [7:0] MINSEC_MAX = MINSEC_MAX_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       hour_en,
   input  logic       min_en,
   input  logic       sec_en,
   input  logic       completeSetting,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       tick_1hz,
   input  logic       cancel,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       alarm,
   output logic       entry_error
);

   state_t     state_q, state_d;
   logic [7:0] hour_q, min_q, sec_q;
   logic [7:0] hour_d, min_d, sec_d;
   logic [7:0] hour_nx, min_nx, sec_nx;
   logic       sec_b, min_b, hour_b;
   logic       cs_p1, val_req_p1;
   logic       err_q, err_d;
   logic       cs_rise, dec_go, key_is_digit, entry_ok, nx_zero;

   assign cs_rise      = completeSetting && !cs_p1;
   assign dec_go       = (state_q == RUN) && tick_1hz && !cancel;
   assign key_is_digit = (key_digit <= 4'd9);

   assign entry_ok = bcd_ok(hour_q) && bcd_ok(min_q) && bcd_ok(sec_q) &&
                     (hour_q <= HOUR_MAX) && (min_q <= MINSEC_MAX) &&
                     (sec_q <= MINSEC_MAX) &&
                     !((hour_q == BCD_ZERO) && (min_q == BCD_ZERO) && (sec_q == BCD_ZERO));

   bcd2_dec u_sec_dec (
      .value      (sec_q),
      .dec_en     (dec_go),
      .wrap       (MINSEC_MAX),
      .next_value (sec_nx),
      .borrow     (sec_b)
   );

   bcd2_dec u_min_dec (
      .value      (min_q),
      .dec_en     (sec_b),
      .wrap       (MINSEC_MAX),
      .next_value (min_nx),
      .borrow     (min_b)
   );

   bcd2_dec u_hour_dec (
      .value      (hour_q),
      .dec_en     (min_b),
      .wrap       (HOUR_MAX),
      .next_value (hour_nx),
      .borrow     (hour_b)
   );

   assign nx_zero = (hour_nx == BCD_ZERO) && (min_nx == BCD_ZERO) && (sec_nx == BCD_ZERO);

   always_comb begin
      state_d = state_q;
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Validation runs one cycle after the rising edge so a digit keyed
            // on that same edge is already in the fields.
            if (val_req_p1) begin
               if (entry_ok) begin
                  state_d = RUN;
               end else begin
                  err_d  = 1'b1;
                  hour_d = BCD_ZERO;
                  min_d  = BCD_ZERO;
                  sec_d  = BCD_ZERO;
               end
            end else if (key_valid && key_is_digit) begin
               if (sec_en)       sec_d  = {sec_q[3:0], key_digit};
               else if (min_en)  min_d  = {min_q[3:0], key_digit};
               else if (hour_en) hour_d = {hour_q[3:0], key_digit};
            end
         end
         RUN: begin
            if (cancel) begin
               state_d = IDLE;
               hour_d  = BCD_ZERO;
               min_d   = BCD_ZERO;
               sec_d   = BCD_ZERO;
            end else if (dec_go) begin
               hour_d = hour_nx;
               min_d  = min_nx;
               sec_d  = sec_nx;
               // A borrow out of hours would mean underflow past zero; treat it as expiry.
               if (nx_zero || hour_b) begin
                  state_d = ALARM;
                  hour_d  = BCD_ZERO;
                  min_d   = BCD_ZERO;
                  sec_d   = BCD_ZERO;
               end
            end
         end
         ALARM: begin
            hour_d = BCD_ZERO;
            min_d  = BCD_ZERO;
            sec_d  = BCD_ZERO;
            if (key_valid || cancel) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            hour_d  = BCD_ZERO;
            min_d   = BCD_ZERO;
            sec_d   = BCD_ZERO;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         hour_q     <= BCD_ZERO;
         min_q      <= BCD_ZERO;
         sec_q      <= BCD_ZERO;
         err_q      <= 1'b0;
         cs_p1      <= 1'b0;
         val_req_p1 <= 1'b0;
      end else begin
         state_q    <= state_d;
         hour_q     <= hour_d;
         min_q      <= min_d;
         sec_q      <= sec_d;
         err_q      <= err_d;
         cs_p1      <= completeSetting;
         val_req_p1 <= cs_rise && (state_q == IDLE);
      end
   end

   assign hour_bcd    = hour_q;
   assign min_bcd     = min_q;
   assign sec_bcd     = sec_q;
   assign running     = (state_q == RUN);
   assign alarm       = (state_q == ALARM);
   assign entry_error = err_q;

endmodule

// File: doc/nap_countdown.md
# nap_countdown

Downstream consumer of the time-entry sequencer. Captures keypad digits into BCD hour/minute/second fields while the matching `*_en` line is high. On `completeSetting` it validates the entry and counts the nap time down once per second. At zero it raises `alarm` and holds it until a key press or `cancel`.

## Interface

Parameters:
- `HOUR_MAX`, default 8'h23: largest accepted BCD hour value.
- `MINSEC_MAX`, default 8'h59: largest accepted BCD minute and second value, and the wrap value used on borrow.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `hour_en` in 1: hour field selected for entry.
- `min_en` in 1: minute field selected for entry.
- `sec_en` in 1: second field selected for entry.
- `completeSetting` in 1: entry-finished level from the sequencer; a level that may stay high for many cycles.
- `key_valid` in 1: one-cycle strobe, keypad digit present.
- `key_digit` in 4: keypad code; 0–9 are digits, 10–15 are non-digit keys.
- `tick_1hz` in 1: one-cycle strobe, once per second.
- `cancel` in 1: abort request.
- `hour_bcd` out 8: hour field as {tens, ones}.
- `min_bcd` out 8: minute field.
- `sec_bcd` out 8: second field.
- `running` out 1: high while in RUN.
- `alarm` out 1: high while in ALARM.
- `entry_error` out 1: one-cycle pulse when the entry is rejected.

## Operation

- State machine:
  - States: IDLE, RUN, ALARM.
  - Reset value: state IDLE; all fields 8'h00; `running`, `alarm`, `entry_error` all 0.
- IDLE, digit entry:
  - Condition: `key_valid` high and `key_digit` ≤ 9.
  - Selected field updates as field ← {field[3:0], key_digit}, i.e. the new digit shifts in at the ones position.
  - Selection priority when several enables are high: `sec_en` > `min_en` > `hour_en`.
  - No enable high, or `key_digit` > 9: the strobe is ignored.
- IDLE, validation:
  - Triggered by the rising edge of `completeSetting`, detected against a registered copy of `completeSetting`.
  - Accept only if all of the following hold:
    - Every BCD nibble ≤ 9.
    - `hour_bcd` ≤ `HOUR_MAX`.
    - `min_bcd` ≤ `MINSEC_MAX` and `sec_bcd` ≤ `MINSEC_MAX`.
    - The three fields are not all zero.
  - Valid: go to RUN; fields are kept and now serve as the countdown.
  - Invalid: pulse `entry_error`, clear all fields, stay in IDLE.
- RUN, countdown:
  - Each `tick_1hz` decrements hh:mm:ss in BCD.
  - Seconds 00 wraps to `MINSEC_MAX` and borrows from minutes.
  - Minutes 00 wraps to `MINSEC_MAX` and borrows from hours.
  - A tick at 00:00:01 produces 00:00:00 and moves to ALARM.
- RUN, other inputs:
  - `cancel` moves to IDLE and clears all fields.
  - `key_valid` and the enables are ignored.
- ALARM:
  - Fields hold 00:00:00.
  - `key_valid` (any code) or `cancel` moves to IDLE.
  - `tick_1hz` is ignored.
- Outputs:
  - `running` = (state == RUN).
  - `alarm` = (state == ALARM).
  - Both are decoded from the registered state, so they are glitch-free.

## Timing

- Digit entry: field changes in the cycle after the `key_valid` edge (latency 1).
- Validation: `completeSetting` rising edge sampled at edge N → `running` or `entry_error` visible after edge N+1.
  - `entry_error` lasts exactly one cycle.
  - `completeSetting` held high: no re-trigger.
- Countdown:
  - A tick in the same cycle as the validating edge is ignored; the first decrement uses the first tick after `running` rises.
  - Decrement and borrow complete in one cycle.
  - At 00:00:01, the tick that zeroes the fields also raises `alarm` on the same edge.
- Simultaneous events:
  - `cancel` with `tick_1hz` in RUN: cancel wins, no decrement.
  - `key_valid` with `completeSetting` rising in IDLE: the digit is written first, and validation sees the updated field on the next cycle.
- Reset asserted mid-count: immediate return to IDLE with all fields 00, independent of `clock`.

## Structure

- Shared package `nap_pkg`:
  - State encodings: IDLE = 2'd0, RUN = 2'd1, ALARM = 2'd2; 2'd3 recovers to IDLE.
  - BCD constants: `BCD_ZERO`, default `HOUR_MAX`, default `MINSEC_MAX`.
- Sub-module `bcd2_dec`: two-digit BCD decrementer.
  - Inputs: value, decrement enable, wrap value.
  - Outputs: next value, borrow.
  - Instantiated three times, chained seconds → minutes → hours.

## Test plan

- Enter hours 0,1; minutes 0,0; seconds 0,3; raise `completeSetting`.
  - → `running`=1, fields 01:00:03.
  - After 4 ticks: 00:59:59.
- Load 00:00:02, apply 2 ticks.
  - → after 1 tick: 00:00:01.
  - → after 2 ticks: 00:00:00 with `alarm`=1 on the same edge.
  - Then a `key_valid` with digit 12 → IDLE, `alarm`=0.
- Enter hours 2,4 and raise `completeSetting`.
  - → one-cycle `entry_error`, fields 00:00:00, `running`=0.
  - Repeat with all fields 00 → same response.
- In RUN at 00:10:00, assert `cancel` and `tick_1hz` together.
  - → IDLE, fields 00:00:00, no decrement.
- With `hour_en` and `sec_en` both high, key 7, then key 11.
  - → `sec_bcd` = 8'h07, `hour_bcd` unchanged.
- Assert `reset` asynchronously mid-RUN at 01:00:00.
  - → all outputs 0 before the next clock edge.
